excalibur_inventory: RTL
========================

Name: excalibur_inventory

Overview:
- Upstream controller for the Excalibur HUD icon renderer.
- Holds the player's Excalibur charge count, from 0 to MAX_COUNT.
- Accepts pickup events and use requests from game logic, and enforces a frame-counted cooldown after each use.
- Drives the renderer's Excalibur_icon_exist and Excalibur_icon_number inputs. The icons blink while the cooldown is running.

Parameters:
- MAX_COUNT, 3: charge saturation value. Must be 3 or less, because the count is 2 bits wide.
- INIT_COUNT, 0: count loaded on reset and on entering IDLE.
- COOLDOWN_FRAMES, 30: frame ticks spent in COOLDOWN after a use, range 1..255.
- BLINK_FRAMES, 8: frame ticks between toggles of the blink phase during COOLDOWN, range 1..255.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  raw vertical-sync-rate frame clock, asynchronous to Clk
- game_active  in  1  high while a level is being played
- pickup  in  1  one-Clk pulse: player collected an Excalibur
- use_req  in  1  one-Clk pulse: player pressed the Excalibur key
- Excalibur_icon_exist  out  1  icon enable to the renderer
- Excalibur_icon_number  out  2  charge count to the renderer
- excalibur_fire  out  1  one-Clk pulse: a use was granted
- cooldown_busy  out  1  high while in COOLDOWN

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, count=INIT_COUNT, cd_cnt=0, blink_cnt=0, blink_phase=0, sync flops=0.
  - Outputs: Excalibur_icon_exist=0, Excalibur_icon_number=INIT_COUNT, excalibur_fire=0, cooldown_busy=0.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is high for exactly one Clk cycle, 3 Clk cycles after the frame_clk edge.
- All outputs are registered. Each output reflects the state/count as updated at the previous Clk edge.
- IDLE state:
  - Count is held at INIT_COUNT.
  - pickup and use_req are ignored.
  - Excalibur_icon_exist=0.
  - game_active=1 moves to READY on the next cycle.
- READY state:
  - pickup: count <= min(count+1, MAX_COUNT). A pickup at MAX_COUNT is dropped silently.
  - use_req with count>0:
    - count <= count-1, excalibur_fire=1 in the next cycle, state <= COOLDOWN.
    - cd_cnt <= COOLDOWN_FRAMES, blink_cnt <= 0, blink_phase <= 0.
  - use_req with count=0: ignored, no fire.
  - pickup and use_req in the same cycle: use is judged against the pre-pickup count.
    - Pre-pickup count>0: count is unchanged and fire is issued. At MAX_COUNT, count stays MAX_COUNT.
    - Pre-pickup count=0: count becomes 1, no fire, stay in READY.
- COOLDOWN state:
  - use_req is ignored and not queued. pickup is applied as in READY.
  - On each tick, cd_cnt decrements.
  - On the tick where cd_cnt==1: state <= READY, blink_phase <= 0.
  - On each tick, blink_cnt increments. When it reaches BLINK_FRAMES it wraps to 0 and blink_phase toggles.
- Icon enable: Excalibur_icon_exist = game_active_state && count!=0 && !(state==COOLDOWN && blink_phase==1).
- Excalibur_icon_number = count, in all states.
- cooldown_busy = (state==COOLDOWN).
- game_active falling to 0 in any state:
  - Next cycle: state=IDLE, count=INIT_COUNT, cd_cnt=0, blink cleared.
  - An in-flight fire pulse already registered still completes.
  - game_active has priority over pickup and use in the same cycle.
- Reset asserted mid-COOLDOWN: all state clears immediately, with no fire and no glitch on the outputs after release.

Test Plan:
- Reset, then game_active=1, then 3 pickups → number=3, exist=1. A 4th pickup → number stays 3.
- count=2 in READY, use_req → next cycle fire=1 for 1 cycle, number=1, cooldown_busy=1. After 30 frame_clk edges → busy=0 within 3 Clk of the 30th edge.
- In COOLDOWN with count=1, BLINK_FRAMES=8 → exist is 1 for ticks 0–7, 0 for ticks 8–15, 1 for ticks 16–23. exist=1 after READY is re-entered.
- use_req during COOLDOWN → no fire, count unchanged. use_req with count=0 in READY → no fire.
- count=0: pickup and use_req in the same cycle → number=1, no fire. count=3: pickup and use_req in the same cycle → number=3, fire=1.
- Mid-COOLDOWN, drop game_active → next cycle number=INIT_COUNT(0), exist=0, busy=0. Assert Reset asynchronously → outputs clear without waiting for a Clk edge.

Source files
------------

// File: rtl/excalibur_inventory_if.sv
// Game-logic side bundle of the Excalibur inventory controller:
// requests in, renderer icon controls and status out.
interface excalibur_inventory_if;
  logic       game_active;
  logic       pickup;
  logic       use_req;
  logic       Excalibur_icon_exist;
  logic [1:0] Excalibur_icon_number;
  logic       excalibur_fire;
  logic       cooldown_busy;

  modport master (
    output game_active,
    output pickup,
    output use_req,
    input  Excalibur_icon_exist,
    input  Excalibur_icon_number,
    input  excalibur_fire,
    input  cooldown_busy
  );

  modport slave (
    input  game_active,
    input  pickup,
    input  use_req,
    output Excalibur_icon_exist,
    output Excalibur_icon_number,
    output excalibur_fire,
    output cooldown_busy
  );
endinterface

// File: rtl/excalibur_inventory.sv
// Excalibur charge inventory: pickups, gated uses with frame-counted
// cooldown, and blinking icon controls for the HUD renderer.
module excalibur_inventory #(
  parameter int unsigned MAX_COUNT       = 3,
  parameter int unsigned INIT_COUNT      = 0,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned BLINK_FRAMES    = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  excalibur_inventory_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_COOL
  } state_t;

  localparam logic [1:0] MAXC = 2'(MAX_COUNT);
  localparam logic [1:0] INITC = 2'(INIT_COUNT);
  localparam logic [7:0] CD_INIT = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] BLINK_M1 = 8'(BLINK_FRAMES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_count;
  logic [1:0] w_count_nxt;
  logic [7:0] r_cd;
  logic [7:0] w_cd_nxt;
  logic [7:0] r_blink;
  logic [7:0] w_blink_nxt;
  logic       r_phase;
  logic       w_phase_nxt;
  logic       w_fire_nxt;
  logic       w_exist_nxt;
  logic [1:0] w_inc;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic       w_tick;

  logic       r_exist;
  logic [1:0] r_number;
  logic       r_fire;
  logic       r_busy;

  // frame_clk is asynchronous: two-flop sync, then rising-edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_sync3;

  assign w_inc = (r_count == MAXC) ? r_count
                                   : r_count + 2'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cd_nxt    = r_cd;
    w_blink_nxt = r_blink;
    w_phase_nxt = r_phase;
    w_fire_nxt  = 1'b0;
    if (!bus.game_active) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = INITC;
      w_cd_nxt    = 8'd0;
      w_blink_nxt = 8'd0;
      w_phase_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_count_nxt = INITC;
          w_state_nxt = S_READY;
        end
        S_READY: begin
          // use is judged on the count before any same-cycle pickup
          if (bus.use_req && r_count != 2'd0) begin
            w_count_nxt = bus.pickup ? r_count
                                     : r_count - 2'd1;
            w_fire_nxt  = 1'b1;
            w_state_nxt = S_COOL;
            w_cd_nxt    = CD_INIT;
            w_blink_nxt = 8'd0;
            w_phase_nxt = 1'b0;
          end else if (bus.pickup) begin
            w_count_nxt = w_inc;
          end
        end
        S_COOL: begin
          if (bus.pickup) begin
            w_count_nxt = w_inc;
          end
          if (w_tick) begin
            w_cd_nxt = r_cd - 8'd1;
            if (r_blink == BLINK_M1) begin
              w_blink_nxt = 8'd0;
              w_phase_nxt = ~r_phase;
            end else begin
              w_blink_nxt = r_blink + 8'd1;
            end
            if (r_cd == 8'd1) begin
              w_state_nxt = S_READY;
              w_phase_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = INITC;
        end
      endcase
    end
    w_exist_nxt = (w_state_nxt != S_IDLE)
                & (w_count_nxt != 2'd0)
                & ~((w_state_nxt == S_COOL)
                    & w_phase_nxt);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count  <= INITC;
      r_cd     <= 8'd0;
      r_blink  <= 8'd0;
      r_phase  <= 1'b0;
      r_exist  <= 1'b0;
      r_number <= INITC;
      r_fire   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_cd     <= w_cd_nxt;
      r_blink  <= w_blink_nxt;
      r_phase  <= w_phase_nxt;
      r_exist  <= w_exist_nxt;
      r_number <= w_count_nxt;
      r_fire   <= w_fire_nxt;
      r_busy   <= (w_state_nxt == S_COOL);
    end
  end

  assign bus.Excalibur_icon_exist  = r_exist;
  assign bus.Excalibur_icon_number = r_number;
  assign bus.excalibur_fire        = r_fire;
  assign bus.cooldown_busy         = r_busy;

endmodule
